// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the seven-segment count display.
//   NUM_DIGITS    number of multiplexed digits on the board display
//   SEG_BLANK     all cathodes off (active-low)
//   SEG_PAT[0:9]  active-low {g,f,e,d,c,b,a} patterns for decimal digits
//   conv_state_t  binary-to-BCD conversion FSM states
//   seg_decode()  nibble -> segment pattern; 10..15 decode to blank
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_PAT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Non-decimal nibbles cannot come out of a correct conversion; show
    // nothing rather than a misleading glyph if one ever does.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] pat;
        pat = SEG_BLANK;
        if (nibble <= 4'd9) begin
            pat = SEG_PAT[nibble];
        end
        return pat;
    endfunction

endpackage

// File: rtl/seg7_count_display_bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one binary bit per clock.
//   clk    in   system clock
//   rst    in   asynchronous active-low reset; aborts any conversion
//   start  in   load bin and begin converting (honoured only while idle)
//   bin    in   CNT_W-bit unsigned value
//   busy   out  high while SHIFT or DONE (new start requests ignored)
//   done   out  one-cycle strobe; bcd holds the complete result this cycle
//   bcd    out  16-bit packed BCD, four nibbles, nibble 0 = units
// Timing: start seen on edge 0, CNT_W shift edges, then one DONE cycle.
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam int SR_W = CNT_W + 16;
    localparam int BC_W = (CNT_W < 2) ? 1 : $clog2(CNT_W);

    conv_state_t      state_reg;
    conv_state_t      state_next;
    logic [SR_W-1:0]  shift_reg;
    logic [SR_W-1:0]  shift_next;
    logic [BC_W-1:0]  bit_cnt_reg;
    logic [BC_W-1:0]  bit_cnt_next;
    logic [15:0]      bcd_adj;

    // Add-3 correction on every BCD nibble that would overflow past 9
    // once doubled by the following shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] =
                (shift_reg[CNT_W + gi*4 +: 4] >= 4'd5)
                    ? shift_reg[CNT_W + gi*4 +: 4] + 4'd3
                    : shift_reg[CNT_W + gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    shift_next   = {16'd0, bin};
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                // The top BCD bit never carries out for inputs up to 13 bits.
                shift_next   = {bcd_adj, shift_reg[CNT_W-1:0]} << 1;
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (bit_cnt_reg == BC_W'(CNT_W - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign bcd  = shift_reg[SR_W-1 -: 16];

endmodule

// File: rtl/seg7_count_display.sv
// -----------------------------------------------------------------------------
// seg7_count_display
// Shows an unsigned binary count in decimal on a four-digit common-anode
// seven-segment display, with optional leading-zero blanking.
//   clk  in   system clock
//   rst  in   asynchronous active-low reset
//   cnt  in   CNT_W-bit binary value, may change any cycle
//   seg  out  cathodes {g,f,e,d,c,b,a}, active-low
//   an   out  anodes, active-low one-hot, an[0] = rightmost digit
//   dp   out  decimal point, active-low, always off
// Parameters: CNT_W (1..13), REFRESH_DIV (clk cycles per digit slot, >= 2),
//   LZ_BLANK (nonzero = blank leading zeros, digit 0 always lit).
// -----------------------------------------------------------------------------
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int CNT_W       = 6,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             dp
);

    generate
        if (CNT_W < 1 || CNT_W > 13) begin : g_bad_cnt_w
            $error("seg7_count_display: CNT_W must be 1..13");
        end
        if (REFRESH_DIV < 2) begin : g_bad_refresh_div
            $error("seg7_count_display: REFRESH_DIV must be >= 2");
        end
    endgenerate

    localparam int PRE_W = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]  last_bin_reg;
    logic [15:0]       disp_bcd;
    logic [PRE_W-1:0]  pre_reg;
    logic [1:0]        idx_reg;
    logic [3:0]        an_reg;
    logic [6:0]        seg_reg;

    logic              conv_start;
    logic              conv_busy;
    logic              conv_done;
    logic [15:0]       conv_bcd;

    logic [NUM_DIGITS-1:1] upper_zero;
    logic [NUM_DIGITS-1:0] digit_blank;
    logic [6:0]            digit_seg [NUM_DIGITS];

    // A change is only acted on while the converter is idle; whatever cnt
    // holds at that moment is what gets converted, so values that come and
    // go during a conversion are simply skipped.
    assign conv_start = !conv_busy && (cnt != last_bin_reg);

    bin2bcd_seq #(
        .CNT_W (CNT_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (cnt),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // disp_bcd is written only from the DONE strobe, so it never holds a
    // partially shifted value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_bin_reg <= '0;
            disp_bcd     <= '0;
        end else begin
            if (conv_start) begin
                last_bin_reg <= cnt;
            end
            if (conv_done) begin
                disp_bcd <= conv_bcd;
            end
        end
    end

    // Digit-slot prescaler and scan index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_reg <= '0;
            idx_reg <= '0;
        end else if (pre_reg == PRE_W'(REFRESH_DIV - 1)) begin
            pre_reg <= '0;
            idx_reg <= idx_reg + 2'd1;
        end else begin
            pre_reg <= pre_reg + 1'b1;
        end
    end

    // Digit i (i > 0) is a leading zero when it and every digit above it
    // are zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_units
                assign digit_blank[gi] = 1'b0;
            end else begin : g_upper
                assign upper_zero[gi]  = (disp_bcd[4*NUM_DIGITS-1 : 4*gi] == '0);
                assign digit_blank[gi] = (LZ_BLANK != 0) && upper_zero[gi];
            end
            assign digit_seg[gi] = digit_blank[gi] ? SEG_BLANK
                                                   : seg_decode(disp_bcd[gi*4 +: 4]);
        end
    endgenerate

    // Registered drive so anode and cathode change together, one clock
    // after the scan index moves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_reg  <= 4'b1110;
            seg_reg <= SEG_PAT[0];
        end else begin
            an_reg  <= ~(4'b0001 << idx_reg);
            seg_reg <= digit_seg[idx_reg];
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = 1'b1;

endmodule
